// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// The head register drives the WB outputs. The skid register absorbs one extra
// entry so that in_ready can be a registered signal.
// Optional feature: define MEM_WB_PERF_EN to enable the saturating stall and
// bubble counters. When it is undefined, both counter ports are tied to 0.
module mem_wb_skid #(
  parameter int XLEN  = 32,
  parameter int RD_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RD_W-1:0]  rd_from_mem,
  input  logic             write_reg_from_mem,
  input  logic             read_mem_from_mem,
  input  logic [XLEN-1:0]  result_from_mem,
  input  logic [XLEN-1:0]  data_from_mem_from_mem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RD_W-1:0]  rd_to_reg,
  output logic             write_reg_to_reg,
  output logic             read_mem_to_wb,
  output logic [XLEN-1:0]  result_to_wb,
  output logic [XLEN-1:0]  data_from_mem_to_wb,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_bubble_cnt
);

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic            write_reg;
    logic            read_mem;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_r, state_next_s;
  entry_t head_r, skid_r, in_entry_s;
  logic   in_ready_r;
  logic   head_v_s, accept_s, pop_s;
  logic   load_head_in_s, load_head_skid_s, load_skid_s;

  assign head_v_s   = (state_r != EMPTY);
  assign accept_s   = in_valid & in_ready_r;
  assign pop_s      = head_v_s & out_ready;
  assign in_entry_s = '{rd: rd_from_mem, write_reg: write_reg_from_mem,
                        read_mem: read_mem_from_mem, result: result_from_mem,
                        data: data_from_mem_from_mem};

  // Next-state and register-load selection. Flush overrides accept and pop.
  always_comb begin
    state_next_s     = state_r;
    load_head_in_s   = 1'b0;
    load_head_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          load_head_in_s = 1'b1;
          state_next_s   = ONE;
        end else begin
          state_next_s   = EMPTY;
        end
      end
      ONE: begin
        if (accept_s && pop_s) begin
          load_head_in_s = 1'b1;
        end else if (accept_s) begin
          load_skid_s    = 1'b1;
          state_next_s   = TWO;
        end else if (pop_s) begin
          state_next_s   = EMPTY;
        end else begin
          state_next_s   = ONE;
        end
      end
      TWO: begin
        if (pop_s) begin
          load_head_skid_s = 1'b1;
          state_next_s     = ONE;
        end else begin
          state_next_s     = TWO;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
    if (flush) begin
      state_next_s     = EMPTY;
      load_head_in_s   = 1'b0;
      load_head_skid_s = 1'b0;
      load_skid_s      = 1'b0;
    end else begin
      state_next_s     = state_next_s;
    end
  end

  // State register. in_ready is registered as "skid will be empty next cycle".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s != TWO);
    end
  end

  // Payload registers. A flush leaves their contents untouched because they
  // are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_head_in_s) begin
        head_r <= in_entry_s;
      end else if (load_head_skid_s) begin
        head_r <= skid_r;
      end else begin
        head_r <= head_r;
      end
      if (load_skid_s) begin
        skid_r <= in_entry_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign in_ready            = in_ready_r;
  assign out_valid           = head_v_s;
  assign rd_to_reg           = head_r.rd;
  assign write_reg_to_reg    = head_r.write_reg & head_v_s;
  assign read_mem_to_wb      = head_r.read_mem;
  assign result_to_wb        = head_r.result;
  assign data_from_mem_to_wb = head_r.data;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r, bubble_cnt_r;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating counters. Only reset clears them, and a flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r  <= '0;
      bubble_cnt_r <= '0;
    end else begin
      if (head_v_s && !out_ready && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (!head_v_s && (bubble_cnt_r != CNT_MAX)) begin
        bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign perf_stall_cnt  = stall_cnt_r;
  assign perf_bubble_cnt = bubble_cnt_r;
`else
  assign perf_stall_cnt  = '0;
  assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed self-checking bench for mem_wb_skid. Inputs change 1 time unit
// after each rising edge, and outputs are sampled at that same point.
module tb_mem_wb_skid;
  localparam int XLEN = 32;
  localparam int RD_W = 5;
`ifdef MEM_WB_PERF_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [RD_W-1:0] rd_from_mem, rd_to_reg;
  logic            write_reg_from_mem, read_mem_from_mem;
  logic            write_reg_to_reg, read_mem_to_wb;
  logic [XLEN-1:0] result_from_mem, data_from_mem_from_mem;
  logic [XLEN-1:0] result_to_wb, data_from_mem_to_wb;
  logic [CNT_W-1:0] perf_stall_cnt, perf_bubble_cnt;

  int checks = 0;
  int errors = 0;

  mem_wb_skid #(.XLEN(XLEN), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_from_mem(rd_from_mem), .write_reg_from_mem(write_reg_from_mem),
    .read_mem_from_mem(read_mem_from_mem), .result_from_mem(result_from_mem),
    .data_from_mem_from_mem(data_from_mem_from_mem),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_to_reg(rd_to_reg), .write_reg_to_reg(write_reg_to_reg),
    .read_mem_to_wb(read_mem_to_wb), .result_to_wb(result_to_wb),
    .data_from_mem_to_wb(data_from_mem_to_wb),
    .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [RD_W-1:0] rd, input logic [XLEN-1:0] res);
    in_valid           = v;
    rd_from_mem        = rd;
    write_reg_from_mem = 1'b1;
    read_mem_from_mem  = 1'b0;
    result_from_mem    = res;
    data_from_mem_from_mem = 32'h0000_0000;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 5'd31, 32'hFFFF_FFFF);
    // 1: reset
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wr", {31'd0, write_reg_to_reg}, 32'd0);
    chk("rst_rd", {27'd0, rd_to_reg}, 32'd0);
    chk("rst_rm", {31'd0, read_mem_to_wb}, 32'd0);
    chk("rst_result", result_to_wb, 32'd0);
    chk("rst_data", data_from_mem_to_wb, 32'd0);
    chk("rst_stall", 32'(perf_stall_cnt), 32'd0);
    chk("rst_bubble", 32'(perf_bubble_cnt), 32'd0);

    // 2: back-to-back stream with out_ready=1
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_rd", {27'd0, rd_to_reg}, 32'(i));
      chk("stream_result", result_to_wb, 32'h100 + 32'(i));
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_wr", {31'd0, write_reg_to_reg}, 32'd1);
    end
    drive(1'b0, 5'd0, 32'd0);
    tick();
    chk("stream_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("stream_drain_wr", {31'd0, write_reg_to_reg}, 32'd0);

    // 3: fill to TWO under backpressure, then release
    out_ready = 1'b0;
    drive(1'b1, 5'd3, 32'h3); tick();
    drive(1'b1, 5'd4, 32'h4); tick();
    chk("two_in_ready", {31'd0, in_ready}, 32'd0);
    chk("two_head_rd", {27'd0, rd_to_reg}, 32'd3);
    drive(1'b1, 5'd5, 32'h5); tick();
    chk("held_rd", {27'd0, rd_to_reg}, 32'd3);
    chk("held_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; tick();
    chk("rel_rd4", {27'd0, rd_to_reg}, 32'd4);
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rel_rd5", {27'd0, rd_to_reg}, 32'd5);
    chk("rel_result5", result_to_wb, 32'h5);
    drive(1'b0, 5'd0, 32'd0); tick();
    chk("rel_empty", {31'd0, out_valid}, 32'd0);

    // 4: flush while in TWO beats accept and pop
    out_ready = 1'b0;
    drive(1'b1, 5'd10, 32'hA); tick();
    drive(1'b1, 5'd11, 32'hB); tick();
    chk("pre_flush_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 5'd12, 32'hC); tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush_wr", {31'd0, write_reg_to_reg}, 32'd0);
    chk("flush_keeps_payload", {27'd0, rd_to_reg}, 32'd10);
    tick();
    chk("flush_stays_empty", {31'd0, out_valid}, 32'd0);

    // 5: load entry held stable across 3 stall cycles
    out_ready = 1'b0;
    drive(1'b1, 5'd7, 32'h1234);
    read_mem_from_mem = 1'b1;
    data_from_mem_from_mem = 32'hDEAD_BEEF;
    tick();
    drive(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_rm", {31'd0, read_mem_to_wb}, 32'd1);
      chk("stall_result", result_to_wb, 32'h1234);
      chk("stall_data", data_from_mem_to_wb, 32'hDEAD_BEEF);
      chk("stall_rd", {27'd0, rd_to_reg}, 32'd7);
    end

    // 6: counters after a long stall (at least 20 stall cycles total)
    for (int i = 0; i < 20; i++) tick();
`ifdef MEM_WB_PERF_EN
    chk("perf_stall_sat", 32'(perf_stall_cnt), 32'd15);
`else
    chk("perf_stall_off", 32'(perf_stall_cnt), 32'd0);
    chk("perf_bubble_off", 32'(perf_bubble_cnt), 32'd0);
`endif

    // Reset arriving mid-transfer beats flush and discards the held entry.
    rst = 1'b1; flush = 1'b1; tick();
    rst = 1'b0; flush = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_result", result_to_wb, 32'd0);
    chk("midrst_data", data_from_mem_to_wb, 32'd0);
    chk("midrst_stall", 32'(perf_stall_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
